// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register bank: FSM states, command encoding, default widths.
package spi_reg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        OVER
    } spi_state_e;

    localparam logic CMD_WRITE = 1'b1;
    localparam logic CMD_READ  = 1'b0;

    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ADDR_W   = 7;

endpackage

// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between the chip pads (controller side) and the register bank (peripheral side).
interface spi_reg_bank_if;

    logic ncs;
    logic sclk;
    logic copi;
    logic cipo;
    logic cipo_oe;

    modport master (output ncs, output sclk, output copi, input cipo, input cipo_oe);
    modport slave  (input ncs, input sclk, input copi, output cipo, output cipo_oe);

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous input plus single-clk rise/fall pulses.
module spi_sync_edge #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    // NOTE: non-blocking assignments keep these three flops a true pipeline;
    // blocking ones would let d ripple straight through in a single edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            dly_q  <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign q    = sync_q;
    assign rise = sync_q & ~dly_q;
    assign fall = ~sync_q & dly_q;

endmodule

// File: rtl/spi_reg_bank.sv
// Mode-0 SPI peripheral register bank with write strobes, frame validation and readback.
// Readback over cipo is built only when SPI_READBACK_EN is defined.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter bit RESET_VAL = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    spi_reg_bank_if.slave              spi,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic [NUM_REGS-1:0]        wr_strobe,
    output logic                       frame_err
);

    localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 2);

    localparam logic [CNT_W-1:0] CNT_ADDR_END = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] CNT_DATA_END = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(FRAME_LEN + 1);

`ifdef SPI_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic ncs_s, ncs_rise, ncs_fall;
    logic sclk_s_unused, sclk_rise, sclk_fall;
    logic copi_s, copi_rise_unused, copi_fall_unused;

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d(spi.ncs),
        .q(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(spi.sclk),
        .q(sclk_s_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .d(spi.copi),
        .q(copi_s), .rise(copi_rise_unused), .fall(copi_fall_unused)
    );

    // The ncs synchroniser resets to "high", so a chip select held low across
    // reset would look like a fresh fall. Only accept a fall after ncs has been
    // genuinely sampled high for three clocks.
    logic [1:0] arm_q;
    logic       armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_q <= 2'd0;
        end else if (!ncs_s) begin
            arm_q <= 2'd0;
        end else if (arm_q != 2'd3) begin
            arm_q <= arm_q + 2'd1;
        end
    end

    assign armed = (arm_q == 2'd3);

    spi_state_e       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q;
    logic             cmd_q;
    logic [ADDR_W-1:0] addr_q, addr_next;
    logic [DATA_W-1:0] data_q, data_next;
    logic             bit_tick, frame_end;

    assign bit_tick  = sclk_rise & ~ncs_s;
    assign frame_end = ncs_rise & (state_q != IDLE);
    assign addr_next = ADDR_W'({addr_q, copi_s});
    assign data_next = DATA_W'({data_q, copi_s});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: state_d gets its default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) begin
            if (ncs_fall && armed) state_d = CMD;
        end else if (ncs_rise) begin
            state_d = IDLE;
        end else if (bit_tick) begin
            case (state_q)
                CMD:     state_d = ADDR;
                ADDR:    if (bit_cnt_q == CNT_ADDR_END) state_d = DATA;
                DATA:    if (bit_cnt_q == CNT_DATA_END) state_d = OVER;
                default: state_d = state_q;
            endcase
        end
    end

    // Shift registers and counter stay cleared while idle, so each frame starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
            cmd_q     <= CMD_READ;
            addr_q    <= '0;
            data_q    <= '0;
        end else if (state_q == IDLE) begin
            bit_cnt_q <= '0;
            cmd_q     <= CMD_READ;
            addr_q    <= '0;
            data_q    <= '0;
        end else if (bit_tick) begin
            if (bit_cnt_q != CNT_SAT) bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            case (state_q)
                CMD:     cmd_q  <= copi_s;
                ADDR:    addr_q <= addr_next;
                DATA:    data_q <= data_next;
                default: ;
            endcase
        end
    end

    logic [NUM_REGS-1:0] addr_hit, commit_vec;
    logic                frame_full, is_write, commit, discard;

    always_comb begin
        addr_hit = '0;
        for (int i = 0; i < NUM_REGS; i++) addr_hit[i] = (addr_q == ADDR_W'(i));
    end

    assign frame_full = (bit_cnt_q == CNT_FULL);
    assign is_write   = (cmd_q == CMD_WRITE);
    assign commit     = frame_end & is_write & frame_full;
    assign commit_vec = commit ? addr_hit : '0;
    assign discard    = frame_end & ((bit_cnt_q == '0)
                      | (is_write & ~(frame_full & (|addr_hit)))
                      | (READBACK & ~is_write & (bit_cnt_q < CNT_FULL)));

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // NOTE: the bank is a handful of configuration flops feeding live logic,
    // not a RAM, so every entry is given a defined reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= {DATA_W{RESET_VAL}};
            wr_strobe <= '0;
            frame_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit_vec[i]) regs_q[i] <= data_q;
            end
            wr_strobe <= commit_vec;
            frame_err <= discard;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end

`ifdef SPI_READBACK_EN
    logic [DATA_W-1:0] rd_sr_q, rd_word;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_next == ADDR_W'(i)) rd_word = regs_q[i];
        end
    end

    // Load on the last address bit; the fall straight after it keeps the MSB on
    // the pin for the first data rise, later falls shift (zero-filling).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sr_q <= '0;
        end else if (state_q == IDLE) begin
            rd_sr_q <= '0;
        end else if (bit_tick && state_q == ADDR && bit_cnt_q == CNT_ADDR_END
                     && cmd_q == CMD_READ) begin
            rd_sr_q <= rd_word;
        end else if (sclk_fall && !ncs_s && bit_cnt_q > CNT_ADDR_END + CNT_W'(1)) begin
            rd_sr_q <= rd_sr_q << 1;
        end
    end

    assign spi.cipo    = rd_sr_q[DATA_W-1] & ~ncs_s;
    assign spi.cipo_oe = ~ncs_s;
`else
    logic sclk_fall_unused;
    assign sclk_fall_unused = sclk_fall;
    assign spi.cipo         = 1'b0;
    assign spi.cipo_oe      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: vector table of SPI frames plus glitch, reset and back-to-back sequences.
module tb_spi_reg_bank;

`ifdef SPI_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] regs_flat;
    logic [7:0]  wr_strobe;
    logic        frame_err;

    spi_reg_bank_if spi ();

    spi_reg_bank #(
        .NUM_REGS(8), .DATA_W(8), .ADDR_W(7), .RESET_VAL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .spi(spi),
        .regs_flat(regs_flat), .wr_strobe(wr_strobe), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         strb_cnt = 0;
    int         err_cnt = 0;
    int         last_strb_cyc = 0;
    logic [7:0] last_strb = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (wr_strobe != '0) begin
            strb_cnt++;
            last_strb     = wr_strobe;
            last_strb_cyc = cyc;
        end
        if (frame_err) err_cnt++;
    end

    int n_chk = 0;
    int n_err = 0;
    int ncs_rise_cyc = 0;
    logic samp_cipo, samp_oe;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clock_bit(input logic b);
        spi.copi = b;
        wclk(4);
        samp_cipo = spi.cipo;
        samp_oe   = spi.cipo_oe;
        spi.sclk  = 1'b1;
        wclk(5);
        spi.sclk  = 1'b0;
        wclk(5);
    endtask

    task automatic send_frame(input logic is_wr, input logic [6:0] addr, input logic [7:0] data,
                              input int nbits, output logic [7:0] rx, output logic [1:0] oe);
        logic [31:0] w;
        w  = {is_wr, addr, data, 16'h0000};
        rx = '0;
        oe = 2'b01;                       // {any high, all high}
        spi.ncs = 1'b0;
        wclk(6);
        for (int k = 0; k < nbits; k++) begin
            clock_bit(w[31-k]);
            if (k >= 8 && k < 16) rx = {rx[6:0], samp_cipo};
            oe = {oe[1] | samp_oe, oe[0] & samp_oe};
        end
        spi.copi     = 1'b0;
        ncs_rise_cyc = cyc;
        spi.ncs      = 1'b1;
    endtask

    typedef struct {
        logic        is_wr;
        int          nbits;
        logic [6:0]  addr;
        logic [7:0]  data;
        logic [7:0]  exp_strb;
        int          exp_err;
        logic [63:0] exp_regs;
        logic        chk_rd;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  rx;
        logic [1:0]  oe;
        logic [31:0] w;
        int          s0, e0, lat;

        vecs[0] = '{1'b1, 16, 7'd2, 8'hA5, 8'h04, 0, 64'h0000_0000_00A5_0000, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 16, 7'd2, 8'h00, 8'h00, 0, 64'h0000_0000_00A5_0000, 1'b1, RB ? 8'hA5 : 8'h00};
        vecs[2] = '{1'b1, 16, 7'd9, 8'h77, 8'h00, 1, 64'h0000_0000_00A5_0000, 1'b0, 8'h00};
        vecs[3] = '{1'b1, 12, 7'd5, 8'h11, 8'h00, 1, 64'h0000_0000_00A5_0000, 1'b0, 8'h00};
        vecs[4] = '{1'b1, 17, 7'd5, 8'h22, 8'h00, 1, 64'h0000_0000_00A5_0000, 1'b0, 8'h00};
        vecs[5] = '{1'b1, 16, 7'd7, 8'h5A, 8'h80, 0, 64'h5A00_0000_00A5_0000, 1'b0, 8'h00};
        vecs[6] = '{1'b0, 16, 7'd7, 8'h00, 8'h00, 0, 64'h5A00_0000_00A5_0000, 1'b1, RB ? 8'h5A : 8'h00};
        vecs[7] = '{1'b0, 16, 7'd9, 8'h00, 8'h00, 0, 64'h5A00_0000_00A5_0000, 1'b1, 8'h00};
        vecs[8] = '{1'b0, 10, 7'd2, 8'h00, 8'h00, RB ? 1 : 0, 64'h5A00_0000_00A5_0000, 1'b0, 8'h00};
        vecs[9] = '{1'b1, 16, 7'd0, 8'hFF, 8'h01, 0, 64'h5A00_0000_00A5_00FF, 1'b0, 8'h00};

        spi.ncs  = 1'b1;
        spi.sclk = 1'b0;
        spi.copi = 1'b0;
        rst_n    = 1'b0;
        wclk(3);
        check("reset regs_flat", regs_flat, 64'h0);
        check("reset wr_strobe", wr_strobe, 8'h00);
        check("reset frame_err", frame_err, 1'b0);
        check("reset cipo", spi.cipo, 1'b0);
        check("reset cipo_oe", spi.cipo_oe, 1'b0);
        rst_n = 1'b1;
        wclk(5);

        for (int v = 0; v < 10; v++) begin
            s0 = strb_cnt;
            e0 = err_cnt;
            send_frame(vecs[v].is_wr, vecs[v].addr, vecs[v].data, vecs[v].nbits, rx, oe);
            wclk(10);
            check($sformatf("v%0d strobe_count", v), strb_cnt - s0, (vecs[v].exp_strb != 0) ? 1 : 0);
            check($sformatf("v%0d strobe_value", v), (strb_cnt != s0) ? last_strb : 8'h00, vecs[v].exp_strb);
            check($sformatf("v%0d frame_err_count", v), err_cnt - e0, vecs[v].exp_err);
            check($sformatf("v%0d regs_flat", v), regs_flat, vecs[v].exp_regs);
            if (vecs[v].nbits == 16) check($sformatf("v%0d cipo_oe", v), oe, RB ? 2'b11 : 2'b00);
            if (vecs[v].chk_rd) check($sformatf("v%0d read_data", v), rx, vecs[v].exp_rd);
            if (v == 0) begin
                lat = last_strb_cyc - ncs_rise_cyc;
                check("v0 commit_latency_3_to_4", (lat >= 3 && lat <= 4), 1'b1);
            end
        end

        // chip-select glitch with no sclk activity
        s0 = strb_cnt;
        e0 = err_cnt;
        spi.ncs = 1'b0;
        wclk(6);
        spi.ncs = 1'b1;
        wclk(10);
        check("glitch frame_err_count", err_cnt - e0, 1);
        check("glitch strobe_count", strb_cnt - s0, 0);
        check("glitch regs_flat", regs_flat, 64'h5A00_0000_00A5_00FF);

        // reset in the middle of the data phase, chip select held low across it
        spi.ncs = 1'b0;
        wclk(6);
        w = {1'b1, 7'd3, 8'hC3, 16'h0000};
        for (int k = 0; k < 12; k++) clock_bit(w[31-k]);
        rst_n = 1'b0;
        wclk(2);
        check("midreset regs_flat", regs_flat, 64'h0);
        check("midreset wr_strobe", wr_strobe, 8'h00);
        check("midreset frame_err", frame_err, 1'b0);
        check("midreset cipo_oe", spi.cipo_oe, 1'b0);
        s0 = strb_cnt;
        e0 = err_cnt;
        rst_n = 1'b1;
        wclk(3);
        for (int k = 12; k < 16; k++) clock_bit(w[31-k]);
        spi.copi = 1'b0;
        spi.ncs  = 1'b1;
        wclk(10);
        check("postreset strobe_count", strb_cnt - s0, 0);
        check("postreset frame_err_count", err_cnt - e0, 0);
        check("postreset regs_flat", regs_flat, 64'h0);

        s0 = strb_cnt;
        send_frame(1'b1, 7'd0, 8'h3C, 16, rx, oe);
        wclk(10);
        check("postreset write strobe_count", strb_cnt - s0, 1);
        check("postreset write strobe_value", last_strb, 8'h01);
        check("postreset write regs_flat", regs_flat, 64'h0000_0000_0000_003C);

        // back-to-back writes with a short ncs-high gap
        s0 = strb_cnt;
        e0 = err_cnt;
        send_frame(1'b1, 7'd1, 8'h12, 16, rx, oe);
        wclk(6);
        send_frame(1'b1, 7'd6, 8'h34, 16, rx, oe);
        wclk(10);
        check("b2b strobe_count", strb_cnt - s0, 2);
        check("b2b last_strobe", last_strb, 8'h40);
        check("b2b frame_err_count", err_cnt - e0, 0);
        check("b2b regs_flat", regs_flat, 64'h0034_0000_0000_123C);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
Parametrised SPI (mode 0) slave register bank; successor to the fixed 5×8-bit write-only SPI config block.
- Generalised in register count, data width and address width.
- Adds readback over CIPO, frame-length validation, and per-register write strobes.
- Sits between the chip SPI pins and the PWM/output-enable logic.
- The register file is exported flat for downstream consumers.

Parameters:
NUM_REGS, 8, number of DATA_W-bit registers (1..2**ADDR_W)
DATA_W, 8, register width and data-phase bit count
ADDR_W, 7, address-phase bit count
RESET_VAL, 0, reset value applied to every register bit

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ncs  in  1  SPI chip select, active low, asynchronous to clk
sclk  in  1  SPI clock, asynchronous to clk
copi  in  1  SPI controller-out data
cipo  out  1  SPI peripheral-out data
cipo_oe  out  1  output enable for cipo pad, high while frame active
regs_flat  out  NUM_REGS*DATA_W  register file, reg i at bits [i*DATA_W +: DATA_W]
wr_strobe  out  NUM_REGS  one-clk pulse on bit i when reg i is committed
frame_err  out  1  one-clk pulse when a frame is discarded

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - regs_flat = RESET_VAL.
  - wr_strobe = 0, frame_err = 0, cipo = 0, cipo_oe = 0.
  - FSM in IDLE, bit counter = 0.
  - Synchroniser flops: ncs = 1, sclk = 0, copi = 0.
- Synchronisation: ncs, sclk and copi each pass through a 2-flop synchroniser. Edges are detected on the synchronised signal against one extra delay flop.
- Frame format: CMD bit (1 = write, 0 = read), then ADDR_W address bits MSB first, then DATA_W data bits MSB first. Total FRAME_LEN = 1+ADDR_W+DATA_W bits.
- Sampling: copi is sampled on the sclk rising-edge pulse only while synchronised ncs is low.
- FSM states and transitions:
  - IDLE -> CMD on ncs fall.
  - CMD -> ADDR after 1 bit.
  - ADDR -> DATA after ADDR_W bits.
  - DATA -> OVER after DATA_W bits.
  - OVER absorbs extra bits.
  - Any state -> IDLE on ncs rise, performing the commit/discard decision in that cycle.
- Bit counter:
  - Width clog2(FRAME_LEN+2).
  - Saturates at FRAME_LEN+1; it never wraps.
- Write commit:
  - Conditions: on the ncs rise, counter == FRAME_LEN, CMD == 1, and address < NUM_REGS.
  - Action: the register is updated and wr_strobe[address] pulses in the same clk.
  - Latency: this is exactly 3 clk edges after ncs high is first captured by the synchroniser.
- Discard:
  - Write frames: an ncs rise with counter != FRAME_LEN, or address >= NUM_REGS, leaves the registers unchanged and pulses frame_err.
  - Read frames: frame_err pulses on a short frame only.
- Read:
  - Once the last address bit is sampled, cipo presents the MSB of the register (0 if address is out of range).
  - Each subsequent sclk falling-edge pulse shifts out the next bit.
  - After DATA_W bits, cipo = 0.
  - Read frames never modify registers.
- cipo_oe equals the inverse of synchronised ncs. cipo is forced 0 when ncs is high.
- Timing constraint: sclk high and low times must each be ≥ 4 clk periods. This is the bench's responsibility; the block performs no checking.
- ncs glitch (fall then rise with no sclk edges): counter = 0 -> frame_err pulses, no register change.
- Reset mid-frame: all state is cleared; a subsequent ncs rise without a preceding fall produces no commit and no error.
- Back-to-back frames: the gap is ≥ 4 clk with ncs high. Each frame is committed independently.

Optional Feature:
SPI_READBACK_EN.
- Defined: read frames return data on cipo as above.
- Undefined:
  - cipo and cipo_oe are tied 0.
  - The readback shift register is not built.
  - Read frames are silently ignored: no commit, and no frame_err even when the read frame is short.

Decomposition:
- Package spi_reg_pkg holds:
  - FSM state enum (IDLE, CMD, ADDR, DATA, OVER).
  - Constants CMD_WRITE = 1 and CMD_READ = 0.
  - Default widths.
- Sub-module spi_sync_edge: 2-flop synchroniser plus rise/fall pulse outputs, with a reset-value parameter. Instantiated for ncs, sclk and copi; the edge outputs of the copi instance are unused.

Test Plan:
- Write reg 2 = 0xA5 (frame 1, 0000010, 10100101) -> regs_flat[23:16] = 0xA5 within 4 clk of ncs rise; wr_strobe = 0x04 for 1 clk; other registers unchanged.
- Read reg 2 after the above -> cipo shifts 1,0,1,0,0,1,0,1 on successive sclk rises; cipo_oe high during frame; regs unchanged, no frame_err.
- Write to address 9 (NUM_REGS = 8) -> no register change, wr_strobe = 0, frame_err pulses once.
- Short write (ncs rises after 12 bits) and long write (17 bits) -> both discarded, frame_err each; no counter wrap, so the 17-bit frame does not alias as a new frame.
- rst_n asserted mid-data-phase, then released -> all regs = RESET_VAL, FSM IDLE; next full write to reg 0 = 0x3C commits normally.
- Build without SPI_READBACK_EN: read reg 0 -> cipo = 0, cipo_oe = 0, no frame_err; writes still commit.
